// File: rtl/shift_sequencer.sv
// Two-requester shift sequencer: round-robin arbitration feeding one shared
// shift register that performs the requested number of single-bit shifts.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_rnl,
  input  logic [AMT_W-1:0] req0_n,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_rnl,
  input  logic [AMT_W-1:0] req1_n,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [AMT_W-1:0] r_cnt;
  logic             r_rnl;
  logic             r_id;
  logic             r_last;

  logic             w_gnt0;
  logic             w_gnt1;
  logic [WIDTH-1:0] w_data;
  logic [AMT_W-1:0] w_n;
  logic             w_rnl;

  // On a tie the requester not granted last wins; r_last=1 favours req0.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == IDLE) begin
      if (req0_valid && req1_valid) begin
        w_gnt0 = r_last;
        w_gnt1 = ~r_last;
      end else begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid;
      end
    end
  end

  assign w_data = w_gnt1 ? req1_data : req0_data;
  assign w_n    = w_gnt1 ? req1_n    : req0_n;
  assign w_rnl  = w_gnt1 ? req1_rnl  : req0_rnl;

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign res_valid  = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign res_data   = r_sreg;
  assign res_id     = r_id;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_rnl   <= 1'b0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_sreg  <= w_data;
            r_cnt   <= w_n;
            r_rnl   <= w_rnl;
            r_id    <= w_gnt1;
            r_last  <= w_gnt1;
            r_state <= (w_n != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          r_sreg <= r_rnl ? {1'b0, r_sreg[WIDTH-1:1]} : {r_sreg[WIDTH-2:0], 1'b0};
          r_cnt  <= r_cnt - AMT_W'(1);
          if (r_cnt == AMT_W'(1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: transaction-level model predicts grants
// and results; a separate monitor checks each presented result.
module tb_shift_sequencer;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  logic             clk;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_data,  req1_data;
  logic             req0_rnl,   req1_rnl;
  logic [AMT_W-1:0] req0_n,     req1_n;
  logic             req0_ready, req1_ready;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_id;
  logic             busy;

  shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_rnl   (req0_rnl),
    .req0_n     (req0_n),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_rnl   (req1_rnl),
    .req1_n     (req1_n),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int data;
    int id;
    int due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_results = 0;

  bit   m_idle = 1'b1;
  bit   m_last = 1'b1;
  int   m_due  = 0;
  bit   acc0   = 1'b0;
  bit   acc1   = 1'b0;
  bit   mon_seen = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int shift_ref(input int d, input int rnl, input int n);
    if (rnl != 0) return d / (1 << n);
    return (d * (1 << n)) % (1 << WIDTH);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: one outstanding command; result due n edges after the accept edge.
  always @(negedge clk or negedge reset) begin
    bit g0, g1;
    if (!reset) begin
      m_idle = 1'b1;
      m_last = 1'b1;
      m_due  = 0;
      acc0   = 1'b0;
      acc1   = 1'b0;
      sb.delete();
    end else begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (m_idle) begin
        if (req0_valid && req1_valid) begin
          if (m_last) g0 = 1'b1; else g1 = 1'b1;
        end else if (req0_valid) g0 = 1'b1;
        else if (req1_valid) g1 = 1'b1;
      end
      check("req0_ready", int'(req0_ready), int'(g0));
      check("req1_ready", int'(req1_ready), int'(g1));
      check("busy", int'(busy), int'(!m_idle));
      acc0 = g0;
      acc1 = g1;
      if (g0 || g1) begin
        exp_t e;
        if (g1) begin
          e.data = shift_ref(int'(req1_data), int'(req1_rnl), int'(req1_n));
          e.id   = 1;
          e.due  = cyc + 1 + int'(req1_n);
        end else begin
          e.data = shift_ref(int'(req0_data), int'(req0_rnl), int'(req0_n));
          e.id   = 0;
          e.due  = cyc + 1 + int'(req0_n);
        end
        sb.push_back(e);
        m_due  = e.due;
        m_idle = 1'b0;
        m_last = g1;
      end else if (!m_idle && cyc >= m_due && res_ready) begin
        m_idle = 1'b1;
      end
    end
  end

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      mon_seen = 1'b0;
    end else if (res_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_result: res_valid=1 data=0x%0h, expected no result", res_data);
      end else begin
        if (!mon_seen) check("res_latency_cycle", cyc, sb[0].due);
        check("res_data", int'(res_data), sb[0].data);
        check("res_id", int'(res_id), sb[0].id);
        mon_seen = 1'b1;
        if (res_ready) begin
          void'(sb.pop_front());
          mon_seen = 1'b0;
          n_results++;
        end
      end
    end else if (sb.size() > 0 && cyc >= sb[0].due) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_result: res_valid=0, expected data 0x%0h id %0d at cycle %0d",
               sb[0].data, sb[0].id, sb[0].due);
      void'(sb.pop_front());
      mon_seen = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input bit v, input int d, input bit rnl, input int n);
    if (id == 0) begin
      req0_valid = v; req0_data = WIDTH'(d); req0_rnl = rnl; req0_n = AMT_W'(n);
    end else begin
      req1_valid = v; req1_data = WIDTH'(d); req1_rnl = rnl; req1_n = AMT_W'(n);
    end
  endtask

  task automatic issue(input int id, input int d, input bit rnl, input int n);
    bit got;
    got = 1'b0;
    set_req(id, 1'b1, d, rnl, n);
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if ((id == 0 && acc0) || (id == 1 && acc1)) got = 1'b1;
    end
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: requester %0d not accepted, expected accept within 40 cycles", id);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && !(sb.size() == 0 && m_idle); i++) tick();
    if (!(sb.size() == 0 && m_idle)) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_id", int'(res_id), 0);
    check("rst_res_data", int'(res_data), 0);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    bit got0, got1;
    reset = 1'b0;
    set_req(0, 1'b0, 0, 1'b0, 0);
    set_req(1, 1'b0, 0, 1'b0, 0);
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("init_busy", int'(busy), 0);
    check("init_res_valid", int'(res_valid), 0);
    check("init_res_id", int'(res_id), 0);
    check("init_res_data", int'(res_data), 0);
    reset = 1'b1;

    issue(0, 'hCC, 1'b1, 2);
    drain();
    issue(1, 'hAA, 1'b0, 1);
    drain();

    // Tie right after reset: req0 first, req1 held until its own grant.
    tick();
    reset_pulse();
    set_req(0, 1'b1, 'hE0, 1'b1, 5);
    set_req(1, 1'b1, 'h01, 1'b0, 7);
    got0 = 1'b0;
    got1 = 1'b0;
    for (int i = 0; i < 60 && !got1; i++) begin
      tick();
      if (acc0) begin got0 = 1'b1; req0_valid = 1'b0; end
      if (acc1) begin got1 = 1'b1; req1_valid = 1'b0; end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("tie_both_granted", int'(got0 && got1), 1);
    drain();

    issue(0, 'h5A, 1'b0, 0);
    drain();

    res_ready = 1'b0;
    issue(0, 'h3C, 1'b1, 1);
    set_req(0, 1'b1, 'h11, 1'b0, 2);
    set_req(1, 1'b1, 'h22, 1'b1, 3);
    repeat (5) tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    drain();

    issue(0, 'hFF, 1'b1, 7);
    repeat (3) tick();
    check("pre_rst_busy", int'(busy), 1);
    reset_pulse();
    issue(1, 'h81, 1'b0, 3);
    drain();

    for (int i = 0; i < 1500; i++) begin
      set_req(0, ($urandom % 2) == 0, int'($urandom % 256), 1'($urandom), int'($urandom % 8));
      set_req(1, ($urandom % 2) == 0, int'($urandom % 256), 1'($urandom), int'($urandom % 8));
      res_ready = ($urandom % 4) != 0;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    drain();
    check("results_seen_nonzero", int'(n_results > 20), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
